// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared encodings and types for the MEM pipeline stage.
// Revision : 1.0
// ============================================================================
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic [1:0]  result_sel;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [31:0] pc_plus4;
    } mreg_t;

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
// Module   : load_store_align
// Purpose  : Byte-lane steering, byte enables and load extension (comb only).
// Revision : 1.0
// ============================================================================
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic        misaligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic        w_byte;
    logic        w_half;
    logic [31:0] w_shifted;
    logic [15:0] w_lane_half;
    logic        w_signed;

    always_comb begin
        w_byte = 1'b0;
        w_half = 1'b0;
        if (is_store_i) begin
            case (funct3_i)
                F3_SB:   w_byte = 1'b1;
                F3_SH:   w_half = 1'b1;
                F3_SW:   w_byte = 1'b0;
                default: w_byte = 1'b0;
            endcase
        end else begin
            case (funct3_i)
                F3_LB, F3_LBU:                   w_byte = 1'b1;
                F3_LH, F3_LHU:                   w_half = 1'b1;
                F3_LW, 3'b011, 3'b110, 3'b111:   w_byte = 1'b0;
                default:                         w_byte = 1'b0;
            endcase
        end
    end

    always_comb begin
        misaligned_o = w_half ? addr_lo_i[0] : (!w_byte && (addr_lo_i != 2'b00));

        if (w_byte) begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{store_data_i[7:0]}};
        end else if (w_half) begin
            be_o    = 4'b0011 << addr_lo_i;
            wdata_o = {2{store_data_i[15:0]}};
        end else begin
            be_o    = 4'b1111;
            wdata_o = store_data_i;
        end
    end

    // funct3[2] set means the unsigned load variants
    always_comb begin
        w_shifted   = rdata_i >> {addr_lo_i, 3'b000};
        w_lane_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        w_signed    = !funct3_i[2];
        if (w_byte) begin
            load_data_o = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
        end else if (w_half) begin
            load_data_o = {{16{w_signed & w_lane_half[15]}}, w_lane_half};
        end else begin
            load_data_o = rdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : MEM stage: EX/MEM register, data-memory handshake, WB register.
// Revision : 1.0
// ============================================================================
module mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic        ex_reg_write_i,
    input  logic        ex_mem_write_i,
    input  logic        ex_mem_read_i,
    input  logic [1:0]  ex_result_sel_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [31:0] ex_alu_result_i,
    input  logic [31:0] ex_store_data_i,
    input  logic [31:0] ex_pc_plus4_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [4:0]  mem_rd_o,
    output logic [31:0] mem_fwd_data_o,
    output logic        mem_reg_write_o,
    output logic        wb_valid_o,
    output logic        wb_reg_write_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_result_o,
    output logic        misalign_err_o,
    output logic        bus_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mreg_t              m_q, m_d;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               w_mem_op;
    logic               w_misaligned;
    logic               w_misalign_hit;
    logic               w_access;
    logic               w_timeout_hit;
    logic               w_req;
    logic               w_done;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_load_data;
    logic [31:0]        w_result;

    load_store_align u_align (
        .funct3_i     (m_q.funct3),
        .is_store_i   (m_q.mem_write),
        .addr_lo_i    (m_q.alu_result[1:0]),
        .store_data_i (m_q.store_data),
        .rdata_i      (dmem_rdata_i),
        .misaligned_o (w_misaligned),
        .be_o         (w_be),
        .wdata_o      (w_wdata),
        .load_data_o  (w_load_data)
    );

    // A bubble from EX clears every field so the M taps read as zero
    always_comb begin
        m_d = '0;
        if (ex_valid_i) begin
            m_d.valid      = 1'b1;
            m_d.reg_write  = ex_reg_write_i;
            m_d.mem_write  = ex_mem_write_i;
            m_d.mem_read   = ex_mem_read_i;
            m_d.result_sel = ex_result_sel_i;
            m_d.funct3     = ex_funct3_i;
            m_d.rd         = ex_rd_i;
            m_d.alu_result = ex_alu_result_i;
            m_d.store_data = ex_store_data_i;
            m_d.pc_plus4   = ex_pc_plus4_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0;
        end else if (!stall_o) begin
            m_q <= m_d;
        end
    end

    assign w_mem_op       = m_q.valid && (m_q.mem_read || m_q.mem_write);
    assign w_misalign_hit = w_mem_op && w_misaligned;
    assign w_access       = w_mem_op && !w_misaligned;
    assign w_timeout_hit  = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT));
    assign w_req          = w_access && !w_timeout_hit;
    assign w_done         = w_req && dmem_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter tracks stalled cycles, so TIMEOUT stalls precede the abort
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req && !dmem_ready_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (w_timeout_hit || w_done || !w_access) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_o      = w_req && !dmem_ready_i;
        dmem_req_o   = w_req;
        dmem_we_o    = w_req && m_q.mem_write;
        dmem_addr_o  = w_req ? {m_q.alu_result[31:2], 2'b00} : 32'd0;
        dmem_be_o    = w_req ? w_be : 4'd0;
        dmem_wdata_o = (w_req && m_q.mem_write) ? w_wdata : 32'd0;
    end

    always_comb begin
        case (m_q.result_sel)
            SEL_LOAD: w_result = w_load_data;
            SEL_PC4:  w_result = m_q.pc_plus4;
            default:  w_result = m_q.alu_result;
        endcase
    end

    assign mem_rd_o        = m_q.rd;
    assign mem_reg_write_o = m_q.valid && m_q.reg_write;
    assign mem_fwd_data_o  = (m_q.result_sel == SEL_PC4) ? m_q.pc_plus4 : m_q.alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_o        <= '0;
            wb_result_o    <= '0;
            misalign_err_o <= 1'b0;
            bus_err_o      <= 1'b0;
        end else if (stall_o) begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            misalign_err_o <= 1'b0;
            bus_err_o      <= 1'b0;
        end else begin
            wb_valid_o     <= m_q.valid;
            wb_reg_write_o <= m_q.valid && m_q.reg_write && !w_misalign_hit && !w_timeout_hit;
            wb_rd_o        <= m_q.rd;
            wb_result_o    <= w_result;
            misalign_err_o <= w_misalign_hit;
            bus_err_o      <= w_timeout_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Randomized scoreboard bench for mem_access with a memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_access;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 0, ex_reg_write = 0, ex_mem_write = 0, ex_mem_read = 0;
    logic [1:0]  ex_result_sel = 0;
    logic [2:0]  ex_funct3 = 0;
    logic [4:0]  ex_rd = 0;
    logic [31:0] ex_alu_result = 0, ex_store_data = 0, ex_pc_plus4 = 0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready = 0;
    logic [31:0] dmem_rdata = 0;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_fwd_data, wb_result;
    logic        mem_reg_write, wb_valid, wb_reg_write, misalign_err, bus_err;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid), .ex_reg_write_i(ex_reg_write),
        .ex_mem_write_i(ex_mem_write), .ex_mem_read_i(ex_mem_read),
        .ex_result_sel_i(ex_result_sel), .ex_funct3_i(ex_funct3), .ex_rd_i(ex_rd),
        .ex_alu_result_i(ex_alu_result), .ex_store_data_i(ex_store_data),
        .ex_pc_plus4_i(ex_pc_plus4), .stall_o(stall),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata), .dmem_be_o(dmem_be),
        .dmem_ready_i(dmem_ready), .dmem_rdata_i(dmem_rdata),
        .mem_rd_o(mem_rd), .mem_fwd_data_o(mem_fwd_data), .mem_reg_write_o(mem_reg_write),
        .wb_valid_o(wb_valid), .wb_reg_write_o(wb_reg_write), .wb_rd_o(wb_rd),
        .wb_result_o(wb_result), .misalign_err_o(misalign_err), .bus_err_o(bus_err)
    );

    typedef struct {
        bit valid, rw, mw, mr;
        bit [1:0] sel; bit [2:0] f3; bit [4:0] rd;
        bit [31:0] alu, sd, pc4;
        int dly;
    } ins_t;
    typedef struct { bit [4:0] rd; bit rw; bit [31:0] res; bit mis, berr; } wb_t;
    typedef struct { bit [31:0] addr; bit we; bit [3:0] be; bit [31:0] wdata; } rq_t;

    wb_t  expq[$];
    rq_t  rqq[$];
    int   dq[$];
    ins_t dirq[$];
    bit [31:0] bmem [256];
    bit [31:0] mmem [256];
    int   vectors = 0, miscompares = 0;
    bit   mon_en = 0;
    bit   last_stall = 0;
    ins_t cur_ex;
    bit   act = 0;
    int   wcnt, rdly, nst, exp_st;
    rq_t  rcur;

    task automatic check(string name, logic [159:0] act_v, logic [159:0] exp_v);
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    function automatic int size_of(bit st, bit [2:0] f3);
        if (st) return (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic ins_t mk(bit mr, bit mw, bit [1:0] sel, bit [2:0] f3, bit [4:0] rd,
                                bit [31:0] alu, bit [31:0] sd, int dly);
        ins_t in;
        in = '{valid: 1, rw: !mw, mw: mw, mr: mr, sel: sel, f3: f3, rd: rd,
               alu: alu, sd: sd, pc4: 32'h4000 + alu, dly: dly};
        return in;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t in;
        int k, r;
        k = $urandom_range(0, 7);
        r = $urandom_range(0, 15);
        in = mk(0, 0, 0, 3'($urandom), 5'($urandom), $urandom, $urandom, 0);
        in.pc4 = $urandom;
        in.valid = (k != 7);
        in.dly = (r < 8) ? 0 : (r < 14) ? r - 7 : (r == 14) ? NEVER : 15;
        if (k <= 2) begin
            r = $urandom_range(0, 2);
            in.sel = (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : 2'd3;
            in.rw  = 1'($urandom);
        end else if (k <= 4) begin
            in.mr = 1; in.sel = 2'd1; in.alu = 32'($urandom_range(0, 1023));
        end else if (k <= 6) begin
            in.mw = 1; in.rw = 0; in.alu = 32'($urandom_range(0, 1023));
        end
        return in;
    endfunction

    // Reference: what the stage must do for one instruction, from first principles
    task automatic model_issue(ins_t in);
        wb_t e; rq_t q;
        int size, lo;
        bit [7:0] widx;
        bit [31:0] mask, v;
        e = '{rd: in.rd, rw: 0, res: (in.sel == 2) ? in.pc4 : in.alu, mis: 0, berr: 0};
        if (in.mr || in.mw) begin
            size = size_of(in.mw, in.f3);
            lo   = int'(in.alu % 4);
            widx = 8'((in.alu / 4) % 256);
            if (in.alu % 32'(size) != 0) begin
                e.mis = 1;
            end else begin
                e.berr = (in.dly >= TIMEOUT);
                q = '{addr: in.alu - 32'(lo), we: in.mw, be: 4'(((1 << size) - 1) << lo), wdata: in.sd};
                if (size == 1) q.wdata = (in.sd % 256) * 32'h0101_0101;
                if (size == 2) q.wdata = (in.sd % 65536) * 32'h0001_0001;
                mask = (size == 4) ? 32'hFFFF_FFFF : 32'(((1 << (8 * size)) - 1) << (8 * lo));
                if (in.mw && !e.berr)
                    mmem[widx] = (mmem[widx] & ~mask) | (q.wdata & mask);
                if (in.mr) begin
                    v = mmem[widx] >> (8 * lo);
                    if (size < 4) v = v % 32'(1 << (8 * size));
                    if (size < 4 && in.f3 < 4 && v >= 32'(1 << (8 * size - 1)))
                        v = v - 32'(1 << (8 * size));
                    e.res = v;
                end
                rqq.push_back(q);
                dq.push_back(in.dly);
            end
        end
        e.rw = in.rw && !e.mis && !e.berr;
        expq.push_back(e);
    endtask

    task automatic drive(ins_t in);
        ex_valid = in.valid; ex_reg_write = in.rw; ex_mem_write = in.mw; ex_mem_read = in.mr;
        ex_result_sel = in.sel; ex_funct3 = in.f3; ex_rd = in.rd;
        ex_alu_result = in.alu; ex_store_data = in.sd; ex_pc_plus4 = in.pc4;
    endtask

    task automatic cycle(bit allow);
        ins_t nx;
        bit fin;
        fin = 0;
        @(negedge clk);
        if (!last_stall) begin
            check("mem_reg_write", mem_reg_write, cur_ex.valid && cur_ex.rw);
            if (cur_ex.valid) begin
                check("mem_rd", mem_rd, cur_ex.rd);
                check("mem_fwd_data", mem_fwd_data, (cur_ex.sel == 2) ? cur_ex.pc4 : cur_ex.alu);
            end
            nx = '{default: 0};
            if (allow) nx = (dirq.size() != 0) ? dirq.pop_front() : rnd_ins();
            drive(nx);
            cur_ex = nx;
            if (nx.valid) model_issue(nx);
        end
        if (dmem_req) begin
            if (!act) begin
                act = 1; wcnt = 0; nst = 0;
                if (rqq.size() == 0 || dq.size() == 0) begin
                    check("req_unexpected", 1, 0);
                    rcur = '{default: 0}; rdly = 0;
                end else begin
                    rcur = rqq.pop_front(); rdly = dq.pop_front();
                end
                exp_st = (rdly < TIMEOUT) ? rdly : TIMEOUT;
            end
            check("dmem_addr", dmem_addr, rcur.addr);
            check("dmem_we", dmem_we, rcur.we);
            if (rcur.we) begin
                check("dmem_be", dmem_be, rcur.be);
                check("dmem_wdata", dmem_wdata, rcur.wdata);
            end
            if (wcnt == rdly) begin
                dmem_ready = 1; fin = 1;
                if (dmem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (dmem_be[b]) bmem[dmem_addr[9:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
                end else begin
                    dmem_rdata = bmem[dmem_addr[9:2]];
                end
            end else begin
                dmem_ready = 0; wcnt++;
            end
        end else begin
            if (act) begin
                check("abort_stall_cycles", nst, exp_st);
                check("abort_only_on_timeout", rdly >= TIMEOUT, 1);
                act = 0;
            end
            dmem_ready = 1'($urandom);
            dmem_rdata = $urandom;
        end
        #1;
        last_stall = stall;
        if (act) begin
            if (stall) nst++;
            if (fin) begin
                check("stall_cycles", nst, exp_st);
                act = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_valid) begin
                if (expq.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    wb_t e;
                    e = expq.pop_front();
                    check("wb_rd", wb_rd, e.rd);
                    check("wb_reg_write", wb_reg_write, e.rw);
                    check("wb_errors", {misalign_err, bus_err}, {e.mis, e.berr});
                    if (e.rw) check("wb_result", wb_result, e.res);
                end
            end else begin
                check("idle_pulses", {wb_reg_write, misalign_err, bus_err}, 3'b000);
            end
        end
    end

    function automatic logic [159:0] all_outs();
        return {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall, mem_rd, mem_fwd_data,
                mem_reg_write, wb_valid, wb_reg_write, wb_rd, wb_result, misalign_err, bus_err};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            bmem[i] = $urandom;
            mmem[i] = bmem[i];
        end
        cur_ex = '{default: 0};
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), '0);
        rst = 0;
        mon_en = 1;

        dirq.push_back(mk(0, 0, 0, 0, 5, 32'h1234, 0, 0));
        dirq.push_back(mk(0, 1, 0, 2, 0, 32'h100, 32'h80FF_FF7F, 0));
        dirq.push_back(mk(1, 0, 1, 0, 6, 32'h103, 0, 0));
        dirq.push_back(mk(1, 0, 1, 4, 7, 32'h103, 0, 0));
        dirq.push_back(mk(0, 1, 0, 1, 0, 32'h202, 32'h0000_ABCD, 0));
        dirq.push_back(mk(1, 0, 1, 2, 8, 32'h100, 0, 3));
        dirq.push_back(mk(1, 0, 1, 2, 9, 32'h102, 0, 0));
        dirq.push_back(mk(1, 0, 1, 2, 10, 32'h104, 0, NEVER));
        dirq.push_back(mk(0, 0, 2, 0, 11, 32'h55, 0, 0));
        dirq.push_back(mk(1, 0, 1, 1, 12, 32'h202, 0, 15));
        repeat (700) cycle(1);
        repeat (40) cycle(0);
        check("drain_phase1", expq.size(), 0);

        // Abort a WAIT with an asynchronous reset between clock edges
        dirq.push_back(mk(1, 0, 1, 2, 3, 32'h10, 0, NEVER));
        cycle(1);
        repeat (4) cycle(0);
        check("pre_reset_req", {dmem_req, stall}, 2'b11);
        #2;
        mon_en = 0;
        rst = 1;
        #1;
        check("async_reset_req_stall", {dmem_req, stall}, 2'b00);
        check("async_reset_outputs", all_outs(), '0);
        expq.delete(); rqq.delete(); dq.delete();
        act = 0; last_stall = 0;
        cur_ex = '{default: 0};
        drive(cur_ex);
        dmem_ready = 0;
        @(negedge clk);
        rst = 0;
        mon_en = 1;

        dirq.push_back(mk(0, 0, 0, 0, 5, 32'h1234, 0, 0));
        dirq.push_back(mk(1, 0, 1, 2, 13, 32'h100, 0, 2));
        repeat (200) cycle(1);
        repeat (40) cycle(0);
        check("drain_phase2", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access.md
# mem_access

Memory stage of the RISC-V pipeline, directly downstream of `execute`. Registers EX results (EX/MEM register), performs loads and stores over a valid/ready data-memory port with byte lanes and sign extension, stalls upstream stages while an access waits, and presents a registered write-back result plus MEM-stage forwarding data. Also detects misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT`, 16: maximum wait cycles for `dmem_ready` before abort.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_reg_write`, `ex_mem_write`, `ex_mem_read`  in  1 each  control from EX.
- `ex_result_sel`  in  2  00 ALU, 01 load data, 10 pc+4; 11 treated as 00.
- `ex_funct3`  in  3  access size/sign.
- `ex_rd`  in  5  destination register.
- `ex_alu_result`  in  32  effective address or ALU result.
- `ex_store_data`  in  32  forwarded rs2 value.
- `ex_pc_plus4`  in  32.
- `stall`  out  1  hold IF/ID/EX; do not advance EX.
- `dmem_req`, `dmem_we`  out  1 each;  `dmem_addr`  out  32 (word-aligned, [1:0]=0);  `dmem_wdata`  out  32;  `dmem_be`  out  4.
- `dmem_ready`  in  1;  `dmem_rdata`  in  32.
- `mem_rd`  out  5;  `mem_fwd_data`  out  32;  `mem_reg_write`  out  1  forwarding taps from the M register.
- `wb_valid`, `wb_reg_write`  out  1;  `wb_rd`  out  5;  `wb_result`  out  32.
- `misalign_err`, `bus_err`  out  1  one-cycle pulses, aligned with `wb_valid`.

## Operation
- M register captures all `ex_*` fields when `!stall`; otherwise holds. `ex_valid=0` captures a bubble.
- Access = M valid and (`mem_read` or `mem_write`) and aligned. Misaligned: word with addr[1:0]≠0, half with addr[0]≠0 → no request, WB gets `wb_reg_write=0`, `misalign_err=1`.
- FSM: IDLE, WAIT. IDLE: on an access, drive `dmem_req`; if `dmem_ready` same cycle, complete; else go to WAIT. WAIT: hold request and all `dmem_*` stable; complete on `dmem_ready`; increment wait counter; when counter reaches `TIMEOUT`, drop request, return to IDLE, WB gets `wb_reg_write=0`, `bus_err=1`. Completion or abort returns to IDLE, counter cleared.
- `stall = access && !dmem_ready && !timeout_hit` (combinational on `dmem_ready`).
- When stalling, the WB register loads a bubble (`wb_valid=0`).
- Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 treated as LW. Lane selected by addr[1:0]; sign/zero-extend to 32.
- Store funct3: 000 SB `be=0001<<addr[1:0]`, data byte replicated ×4; 001 SH `be=0011<<addr[1:0]`, half replicated ×2; 010 SW `be=1111`; others treated as SW.
- `mem_fwd_data` = ALU result, or pc+4 when `result_sel=10` (load data not forwarded from M).

## Timing
- Reset: FSM IDLE, counter 0, M and WB invalid, every output 0 (`dmem_*`, `stall`, `wb_*`, `mem_*`, error pulses).
- Non-memory instruction: captured at edge N, on `wb_*` after edge N+1.
- Zero-wait access: same as non-memory, no stall. k wait cycles: stall k cycles, WB after edge of the `dmem_ready` cycle.
- Timeout: `stall` high for `TIMEOUT` cycles, then released.
- `dmem_ready` outside a request ignored.
- Reset mid-WAIT: `dmem_req` deasserts immediately (async); transaction discarded.

## Structure
- Package `mem_pkg`: funct3 constants (LB…SW), result_sel encodings, FSM state enum.
- Sub-module `load_store_align`: combinational byte-lane/byte-enable/extension logic.
- Counter width `$clog2(TIMEOUT+1)`.

## Test plan
- ADD-type, `ex_alu_result=0x1234`, `ex_result_sel=00`, rd=5 → one cycle later `wb_result=0x1234`, `wb_rd=5`, `wb_reg_write=1`, no stall.
- LB addr `0x103`, `dmem_rdata=0x80FF_FF7F`, ready same cycle → `dmem_addr=0x100`, `wb_result=0xFFFF_FF80`; LBU → `0x0000_0080`.
- SH addr `0x202`, data `0xABCD` → `dmem_be=1100`, `dmem_wdata=0xABCD_ABCD`, `dmem_we=1`.
- LW with `dmem_ready` delayed 3 cycles → `stall` high exactly 3 cycles, `dmem_addr` stable, EX inputs not captured, then correct `wb_result`.
- LW addr `0x102` → no `dmem_req`, `misalign_err` pulse, `wb_reg_write=0`; ready never asserted with `TIMEOUT=16` → 16 stall cycles then `bus_err` pulse.
- Assert `rst` during WAIT → `dmem_req` and `stall` drop without a clock edge; post-reset, first instruction processed normally.
